// File: rtl/rtmc_spi_host.sv
// rtmc_spi_host
//   SPI (mode 0) register-access host. It accepts one read or write request
//   at a time and serialises it as a single chip-select frame:
//   {R/W, address, data}, MSB first. R/W is 1 for a write. The data field is
//   req_wdat for writes and zero for reads. The last DATA_W bits sampled from
//   sdi are returned on rsp_rdat with a one-cycle rsp_valid pulse.
//
//   Optional build macro: RTMC_SPI_HOST_TURNAROUND_EN
//     When defined, read frames carry one extra dummy sck pulse between the
//     address and data phases. sdo is 0 during that pulse and sdi is not
//     sampled on it. Write frames are unchanged.
//
// Parameters
//   ADDR_W  : register address width
//   DATA_W  : register data width (>= 2)
//   CLK_DIV : clk cycles per sck half-period (1..255)
//
// Ports
//   clk, rst_n             : system clock (rising edge), async active-low reset
//   req_valid / req_ready  : request handshake; ready only while idle
//   req_wr, req_addr,
//   req_wdat               : request fields, latched on acceptance
//   rsp_valid, rsp_rdat    : completion pulse and sampled data (rdat is held)
//   sck, cs_n, sdo, sdi    : SPI bus
module rtmc_spi_host #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdat,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdat,
  output logic              sck,
  output logic              cs_n,
  output logic              sdo,
  input  logic              sdi
);

  localparam int N = 1 + ADDR_W + DATA_W;
`ifdef RTMC_SPI_HOST_TURNAROUND_EN
  localparam int TA = 1;
`else
  localparam int TA = 0;
`endif
  localparam int NMAX  = N + TA;
  // Sized for NMAX+1 so the pulse index can never wrap inside a frame.
  localparam int CNT_W = $clog2(NMAX + 2);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Frame image, left-aligned in an NMAX-bit register. With the turnaround
  // enabled, a read's dummy bit and zero data field are both zero, so one
  // trailing pad bit gives the correct image for both frame kinds.
  function automatic logic [NMAX-1:0] build_frame(input logic              wr,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] wdat);
    logic [NMAX-1:0] f;
`ifdef RTMC_SPI_HOST_TURNAROUND_EN
    f = {wr, addr, (wr ? wdat : {DATA_W{1'b0}}), 1'b0};
`else
    f = {wr, addr, (wr ? wdat : {DATA_W{1'b0}})};
`endif
    return f;
  endfunction

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                sck_q, sck_d;
  logic                cs_n_q, cs_n_d;
  logic                sdo_q, sdo_d;
  logic                rdy_q, rdy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdat_q, rsp_rdat_d;
  logic [NMAX-1:0]     tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                rd_q, rd_d;

  logic                half_end;
  logic [CNT_W-1:0]    last_pulse;
  logic                skip;

  assign half_end   = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_pulse = (rd_q && (TA == 1)) ? CNT_W'(NMAX - 1) : CNT_W'(N - 1);

  // skip is evaluated on the low half that precedes pulse bit_q+1; it marks
  // the dummy pulse that immediately follows the last address bit.
`ifdef RTMC_SPI_HOST_TURNAROUND_EN
  assign skip = rd_q && (bit_q == CNT_W'(ADDR_W));
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    sdo_d       = sdo_q;
    rdy_d       = rdy_q;
    rsp_valid_d = 1'b0;
    rsp_rdat_d  = rsp_rdat_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_d        = rd_q;

    if (state_q != IDLE) begin
      div_d = half_end ? '0 : div_q + DIV_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        div_d = '0;
        rdy_d = 1'b1;
        if (req_valid && rdy_q) begin
          state_d = SETUP;
          rdy_d   = 1'b0;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          bit_d   = '0;
          rd_d    = ~req_wr;
          tx_d    = build_frame(req_wr, req_addr, req_wdat);
          sdo_d   = tx_d[NMAX-1];
        end
      end
      SETUP: begin
        if (half_end) begin
          state_d = SHIFT;
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], sdi};
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (sck_q) begin
            // Falling edge: advance sdo unless this was the final pulse.
            sck_d = 1'b0;
            if (bit_q != last_pulse) begin
              tx_d  = {tx_q[NMAX-2:0], 1'b0};
              sdo_d = tx_q[NMAX-2];
            end
          end else if (bit_q == last_pulse) begin
            state_d = HOLD;
          end else begin
            // Rising edge: the device has held sdi stable since the last fall.
            bit_d = bit_q + CNT_W'(1);
            sck_d = 1'b1;
            if (!skip) begin
              rx_d = {rx_q[DATA_W-2:0], sdi};
            end
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          state_d     = GAP;
          cs_n_d      = 1'b1;
          sdo_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdat_d  = rx_q;
        end
      end
      GAP: begin
        if (half_end) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      sdo_q       <= 1'b0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdat_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      sdo_q       <= sdo_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdat_q  <= rsp_rdat_d;
    end
  end

  // Frame and capture shifters are fully rewritten before use in every frame.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
    rd_q <= rd_d;
  end

  assign req_ready = rdy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdat  = rsp_rdat_q;
  assign sck       = sck_q;
  assign cs_n      = cs_n_q;
  assign sdo       = sdo_q;

endmodule

// File: tb/tb_rtmc_spi_host.sv
// Bench for rtmc_spi_host: directed requests against a behavioural SPI
// register device; expected responses go to a scoreboard queue and a monitor
// compares them whenever rsp_valid is seen.
module tb_rtmc_spi_host;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 2;
  localparam int N       = 1 + ADDR_W + DATA_W;
`ifdef RTMC_SPI_HOST_TURNAROUND_EN
  localparam int TA = 1;
`else
  localparam int TA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdat;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdat;
  logic              sck, cs_n, sdo, sdi;

  rtmc_spi_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdat(req_wdat),
    .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat),
    .sck(sck), .cs_n(cs_n), .sdo(sdo), .sdi(sdi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- device model ----------------
  logic [DATA_W-1:0] mem [256];
  bit                wrt [256];
  logic [31:0]       cap = '0;
  int                dev_cnt = 0;
  logic              dev_wr;
  logic [DATA_W-1:0] dev_val;
  int                frm_cnt;
  logic [31:0]       frm_bits;
  logic              dev_sdi;
  int                eff, st;

  function automatic logic [DATA_W-1:0] rdmem(input logic [7:0] a);
    if (wrt[a]) return mem[a];
    if (a == 8'h05) return 16'hA5C3;
    return {a, ~a};
  endfunction

  // cs_n fall (sck low) restarts the frame; sck rise captures sdo.
  always @(posedge sck or negedge cs_n) begin
    if (!sck) begin
      dev_cnt <= 0;
      cap     <= '0;
    end else begin
      cap     <= {cap[30:0], sdo};
      dev_cnt <= dev_cnt + 1;
      if (dev_cnt == ADDR_W) begin
        dev_wr  <= cap[ADDR_W-1];
        dev_val <= rdmem({cap[ADDR_W-2:0], sdo});
      end
    end
  end

  always @(posedge cs_n) begin
    frm_cnt  <= dev_cnt;
    frm_bits <= cap;
    if (dev_wr === 1'b1 && dev_cnt == N) begin
      mem[cap[DATA_W +: ADDR_W]] <= cap[DATA_W-1:0];
      wrt[cap[DATA_W +: ADDR_W]] <= 1'b1;
    end
  end

  // Mode-0 slave output: bit changes after each falling edge. A 1 is driven
  // across a read's dummy pulse so a host that samples it gets wrong data.
  always_comb begin
    eff     = sck ? dev_cnt - 1 : dev_cnt;
    st      = 1 + ADDR_W + ((TA == 1 && dev_wr === 1'b0) ? 1 : 0);
    dev_sdi = 1'b0;
    if (!cs_n) begin
      if (eff >= st && eff - st < DATA_W) dev_sdi = dev_val[DATA_W-1-(eff-st)];
      else if (TA == 1 && dev_wr === 1'b0 && eff == 1 + ADDR_W) dev_sdi = 1'b1;
    end
  end
  assign sdi = dev_sdi;

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic              wr;
    logic [7:0]        addr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rdat;
    int                t;
  } exp_t;
  exp_t sbq[$];

  int cs_fall_cyc = 0;
  int hi_run      = 0;
  int idle_bad    = 0;
  logic prev_cs   = 1'b1;

  initial begin
    exp_t        e;
    int          nb;
    logic [31:0] ef;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e  = sbq.pop_front();
          nb = e.wr ? N : N + TA;
          if (e.wr) ef = {7'd0, 1'b1, e.addr, e.wdat};
          else      ef = {24'd0, e.addr} << (DATA_W + TA);
          check("rsp_rdat",    32'(rsp_rdat), 32'(e.rdat));
          check("rsp_latency", 32'(cyc), 32'(e.t + 1 + CLK_DIV * (2 * nb + 2)));
          check("cs_fall_cyc", 32'(cs_fall_cyc), 32'(e.t + 1));
          check("sck_pulses",  32'(frm_cnt), 32'(nb));
          check("sdo_frame",   frm_bits, ef);
        end
      end
      if (cs_n === 1'b1 && (sck !== 1'b0 || sdo !== 1'b0)) idle_bad++;
      if (prev_cs === 1'b1 && cs_n === 1'b0) begin
        check("cs_high_gap", 32'(hi_run >= CLK_DIV), 32'd1);
        cs_fall_cyc = cyc;
      end
      hi_run  = (cs_n === 1'b1) ? hi_run + 1 : 0;
      prev_cs = cs_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [7:0] a, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] rd, input bit keep, input bit expect_rsp);
    int w;
    exp_t e;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdat  = wd;
    w = 0;
    while (req_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) begin
      check("req_accept_timeout", 32'd0, 32'd1);
    end else if (expect_rsp) begin
      e.wr = wr; e.addr = a; e.wdat = wd; e.rdat = rd; e.t = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    // Scramble the fields: the frame in flight must not follow them.
    req_wr   = ~wr;
    req_addr = ~a;
    req_wdat = ~wd;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdat  = '0;
    #12;
    check("rst_cs_n",      32'(cs_n), 32'd1);
    check("rst_sck",       32'(sck), 32'd0);
    check("rst_sdo",       32'(sdo), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdat",  32'(rsp_rdat), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 32'(req_ready), 32'd1);
    @(negedge clk);

    issue(1'b1, 8'h12, 16'hBEEF, 16'h12ED, 1'b0, 1'b1);
    issue(1'b0, 8'h05, 16'h0000, 16'hA5C3, 1'b0, 1'b1);
    issue(1'b0, 8'h12, 16'h5555, 16'hBEEF, 1'b0, 1'b1);
    // back-to-back with req_valid held high
    issue(1'b1, 8'h30, 16'h1234, 16'h30CF, 1'b1, 1'b1);
    issue(1'b0, 8'h30, 16'h0000, 16'h1234, 1'b1, 1'b1);
    issue(1'b1, 8'h7F, 16'h0000, 16'h7F80, 1'b1, 1'b1);
    issue(1'b0, 8'hFF, 16'hFFFF, 16'hFF00, 1'b1, 1'b1);
    issue(1'b0, 8'h00, 16'h0000, 16'h00FF, 1'b0, 1'b1);
    drain();

    // reset in the middle of a read frame, once 10 sck pulses have gone out
    issue(1'b0, 8'h12, 16'h0000, 16'h0000, 1'b0, 1'b0);
    w = 0;
    while (dev_cnt < 10 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (dev_cnt < 10) check("mid_frame_timeout", 32'(dev_cnt), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n",      32'(cs_n), 32'd1);
    check("abort_sck",       32'(sck), 32'd0);
    check("abort_sdo",       32'(sdo), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 8'h12, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    issue(1'b1, 8'h80, 16'hFFFF, 16'h807F, 1'b0, 1'b1);
    issue(1'b0, 8'h80, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    check("idle_sck_sdo_quiet", 32'(idle_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
